// File: rtl/cc_cond_unit.sv
// Condition-code register, branch/cmov condition evaluation and the E->M copies
// of the condition result and adjusted destination register.
module cc_cond_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_ifun,
  input  logic [3:0] E_dstE,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  input  logic       M_stall,
  input  logic       M_bubble,
  output logic [2:0] cc,
  output logic       e_cnd,
  output logic [3:0] e_dstE,
  output logic       M_cnd,
  output logic [3:0] M_dstE
);

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [2:0] CC_RST  = 3'b100;

  logic [2:0] cc_q, cc_d;
  logic       m_cnd_q, m_cnd_d;
  logic [3:0] m_dste_q, m_dste_d;
  logic       set_cc;
  logic       zf, sf, of;
  logic       cond;

  always_comb begin
    // An OPq only commits flags if nothing older in the pipe has faulted.
    set_cc = (E_icode == I_OPQ) && (m_stat == 2'd0) && (W_stat == 2'd0);
    cc_d   = set_cc ? {alu_zf, alu_sf, alu_of} : cc_q;
  end

  // Conditions always read the registered flags, never the in-flight ALU flags.
  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    e_cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond : 1'b0;
    e_dstE = ((E_icode == I_CMOV) && !e_cnd) ? R_NONE : E_dstE;
  end

  always_comb begin
    m_cnd_d  = m_cnd_q;
    m_dste_d = m_dste_q;
    // Stall wins over bubble so a held instruction is never squashed.
    if (!M_stall) begin
      if (M_bubble) begin
        m_cnd_d  = 1'b0;
        m_dste_d = R_NONE;
      end else begin
        m_cnd_d  = e_cnd;
        m_dste_d = e_dstE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q     <= CC_RST;
      m_cnd_q  <= 1'b0;
      m_dste_q <= R_NONE;
    end else begin
      cc_q     <= cc_d;
      m_cnd_q  <= m_cnd_d;
      m_dste_q <= m_dste_d;
    end
  end

  assign cc     = cc_q;
  assign M_cnd  = m_cnd_q;
  assign M_dstE = m_dste_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Table-driven bench for cc_cond_unit with a queue of expected E->M register values.
module tb_cc_cond_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] E_icode, E_ifun, E_dstE;
  logic       alu_zf, alu_sf, alu_of;
  logic [1:0] m_stat, W_stat;
  logic       M_stall, M_bubble;
  logic [2:0] cc;
  logic       e_cnd;
  logic [3:0] e_dstE;
  logic       M_cnd;
  logic [3:0] M_dstE;

  cc_cond_unit dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .cc(cc), .e_cnd(e_cnd), .e_dstE(e_dstE),
    .M_cnd(M_cnd), .M_dstE(M_dstE)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] dste;
    logic [2:0] flags;
    logic [1:0] ms;
    logic [1:0] ws;
    logic       st;
    logic       bb;
    logic [2:0] exp_cc;
    logic       exp_cnd;
    logic [3:0] exp_dste;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  logic [4:0] exp_q[$];
  logic [4:0] m_model;
  logic [4:0] exp_m;
  int n_pass, n_total;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    E_icode  = v.icode;
    E_ifun   = v.ifun;
    E_dstE   = v.dste;
    {alu_zf, alu_sf, alu_of} = v.flags;
    m_stat   = v.ms;
    W_stat   = v.ws;
    M_stall  = v.st;
    M_bubble = v.bb;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    // icode ifun dstE flags ms ws stall bubble | cc-before cnd dstE
    tbl[0]  = '{4'h7, 4'h3, 4'h5, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b100, 1'b1, 4'h5};
    tbl[1]  = '{4'h6, 4'h0, 4'h2, 3'b010, 2'd0, 2'd0, 1'b0, 1'b0, 3'b100, 1'b0, 4'h2};
    tbl[2]  = '{4'h7, 4'h2, 4'hF, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b010, 1'b1, 4'hF};
    tbl[3]  = '{4'h7, 4'h5, 4'h4, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h4};
    tbl[4]  = '{4'h6, 4'h0, 4'h1, 3'b001, 2'd3, 2'd0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1};
    tbl[5]  = '{4'h6, 4'h0, 4'h1, 3'b001, 2'd0, 2'd2, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1};
    tbl[6]  = '{4'h6, 4'h0, 4'h6, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h6};
    tbl[7]  = '{4'h2, 4'h3, 4'h3, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 4'hF};
    tbl[8]  = '{4'h2, 4'h4, 4'h3, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'h3};
    tbl[9]  = '{4'h2, 4'h4, 4'h3, 3'b000, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000, 1'b1, 4'h3};
    tbl[10] = '{4'h2, 4'h3, 4'h3, 3'b000, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000, 1'b0, 4'hF};
    tbl[11] = '{4'h2, 4'h4, 4'h3, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1, 3'b000, 1'b1, 4'h3};
    tbl[12] = '{4'h7, 4'h6, 4'h7, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'h7};
    tbl[13] = '{4'h7, 4'h9, 4'h8, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};
    tbl[14] = '{4'h3, 4'h0, 4'h9, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h9};
    tbl[15] = '{4'h2, 4'h0, 4'hA, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'hA};
    tbl[16] = '{4'h6, 4'h0, 4'hB, 3'b011, 2'd0, 2'd0, 1'b1, 1'b0, 3'b000, 1'b0, 4'hB};
    tbl[17] = '{4'h7, 4'h1, 4'h0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b011, 1'b0, 4'h0};
    tbl[18] = '{4'h7, 4'h4, 4'hC, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 3'b011, 1'b1, 4'hC};

    rst_n = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cc", {5'd0, cc}, 8'h04);
    chk("reset_M_cnd", {7'd0, M_cnd}, 8'h00);
    chk("reset_M_dstE", {4'd0, M_dstE}, 8'h0F);
    chk("reset_e_cnd_je", {7'd0, e_cnd}, 8'h01);
    m_model = {1'b0, 4'hF};

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_cc", i), {5'd0, cc}, {5'd0, tbl[i].exp_cc});
      chk($sformatf("v%0d_e_cnd", i), {7'd0, e_cnd}, {7'd0, tbl[i].exp_cnd});
      chk($sformatf("v%0d_e_dstE", i), {4'd0, e_dstE}, {4'd0, tbl[i].exp_dste});
      if (!tbl[i].st) m_model = tbl[i].bb ? {1'b0, 4'hF} : {tbl[i].exp_cnd, tbl[i].exp_dste};
      exp_q.push_back(m_model);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue_empty", i), 8'h01, 8'h00);
      end else begin
        exp_m = exp_q.pop_front();
        chk($sformatf("v%0d_M", i), {3'd0, M_cnd, M_dstE}, {3'd0, exp_m});
      end
    end

    // Flags written by the stalled OPq in the table are visible now.
    @(negedge clk);
    chk("post_cc_011", {5'd0, cc}, 8'h03);

    // Async reset between edges with a pending OPq update on the inputs.
    E_icode = 4'h6;
    {alu_zf, alu_sf, alu_of} = 3'b010;
    m_stat = 2'd0;
    W_stat = 2'd0;
    M_stall = 1'b0;
    M_bubble = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_cc", {5'd0, cc}, 8'h04);
    chk("async_M_dstE", {4'd0, M_dstE}, 8'h0F);
    chk("async_M_cnd", {7'd0, M_cnd}, 8'h00);
    @(posedge clk);
    #1;
    chk("held_reset_cc", {5'd0, cc}, 8'h04);
    @(negedge clk);
    E_icode = 4'h7;
    E_ifun  = 4'h3;
    E_dstE  = 4'h2;
    rst_n   = 1'b1;
    #1;
    chk("after_rst_e_cnd", {7'd0, e_cnd}, 8'h01);
    @(posedge clk);
    #1;
    chk("after_rst_M", {3'd0, M_cnd, M_dstE}, {3'd0, 1'b1, 4'h2});
    chk("after_rst_cc", {5'd0, cc}, 8'h04);

    // Random undefined icode/ifun: outputs must stay known.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      E_icode = 4'($urandom_range(8, 15));
      E_ifun  = 4'($urandom_range(0, 15));
      E_dstE  = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("rnd%0d_e_cnd", k), {7'd0, e_cnd}, 8'h00);
      chk($sformatf("rnd%0d_e_dstE", k), {4'd0, e_dstE}, {4'd0, E_dstE});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
